// File: rtl/dest_sel_pipe_if.sv
// Bundle between the issue slot, the destination pipeline
// and the forwarding unit.
interface dest_sel_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        src_a;
  logic [WIDTH-1:0]        src_b;
  logic [DEPTH*WIDTH-1:0]  stage_dest;
  logic [DEPTH-1:0]        stage_valid;
  logic [WIDTH-1:0]        out_dest;
  logic                    out_valid;
  logic [DEPTH-1:0]        fwd_a_match;
  logic [DEPTH-1:0]        fwd_a_pri;
  logic [DEPTH-1:0]        fwd_b_match;
  logic [DEPTH-1:0]        fwd_b_pri;
  logic                    sel_err;

  modport master (
    output in_bus, sel, in_valid, stall, flush,
    output src_a, src_b,
    input  stage_dest, stage_valid,
    input  out_dest, out_valid,
    input  fwd_a_match, fwd_a_pri,
    input  fwd_b_match, fwd_b_pri,
    input  sel_err
  );

  modport slave (
    input  in_bus, sel, in_valid, stall, flush,
    input  src_a, src_b,
    output stage_dest, stage_valid,
    output out_dest, out_valid,
    output fwd_a_match, fwd_a_pri,
    output fwd_b_match, fwd_b_pri,
    output sel_err
  );
endinterface

// File: rtl/dest_sel_pipe.sv
// Destination-register select with an EX/MEM/WB shift pipeline
// and per-stage forwarding-hazard match vectors.
module dest_sel_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3
) (
  input logic          clk,
  input logic          rst,
  dest_sel_pipe_if.slave bus
);

  logic [WIDTH-1:0]       dest_q [DEPTH];
  logic [DEPTH-1:0]       vld_q;
  logic                   err_q;
  logic [WIDTH-1:0]       mux_out;
  logic                   sel_ok;
  logic [DEPTH*WIDTH-1:0] dest_flat;
  logic [DEPTH-1:0]       ma;
  logic [DEPTH-1:0]       mb;

  assign sel_ok = 32'(bus.sel) < 32'(NUM_IN);

  // Out-of-range selects fall through to zero.
  always_comb begin
    mux_out = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k))
        mux_out = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        dest_q[i] <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
    end else if (bus.flush) begin
      vld_q <= '0;
      err_q <= 1'b0;
    end else if (bus.stall) begin
      err_q <= 1'b0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        dest_q[i] <= dest_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
      dest_q[0] <= mux_out;
      vld_q[0]  <= bus.in_valid && sel_ok;
      err_q     <= bus.in_valid && !sel_ok;
    end
  end

  // Register 0 is hardwired and never a forwarding source.
  always_comb begin
    dest_flat = '0;
    ma = '0;
    mb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dest_flat[i*WIDTH +: WIDTH] = dest_q[i];
      ma[i] = vld_q[i] && (dest_q[i] == bus.src_a)
              && (bus.src_a != '0);
      mb[i] = vld_q[i] && (dest_q[i] == bus.src_b)
              && (bus.src_b != '0);
    end
  end

  assign bus.stage_dest  = dest_flat;
  assign bus.stage_valid = vld_q;
  assign bus.out_dest    = dest_q[DEPTH-1];
  assign bus.out_valid   = vld_q[DEPTH-1];
  assign bus.fwd_a_match = ma;
  assign bus.fwd_b_match = mb;
  assign bus.fwd_a_pri   = ma & (~ma + DEPTH'(1));
  assign bus.fwd_b_pri   = mb & (~mb + DEPTH'(1));
  assign bus.sel_err     = err_q;

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Bench for dest_sel_pipe: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_dest_sel_pipe;
  localparam int W  = 5;
  localparam int NI = 3;
  localparam int SW = 2;
  localparam int D  = 3;

  typedef struct packed {
    logic [W-1:0] d;
    logic         v;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  ent_t    pipe[$];
  bit      ref_err;
  logic [W-1:0] cand [NI];

  dest_sel_pipe_if #(.WIDTH(W), .NUM_IN(NI), .SEL_W(SW), .DEPTH(D)) bus ();

  dest_sel_pipe #(.WIDTH(W), .NUM_IN(NI), .SEL_W(SW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    ent_t z;
    z.d = '0;
    z.v = 1'b0;
    pipe.delete();
    for (int i = 0; i < D; i++) pipe.push_back(z);
    ref_err = 1'b0;
  endfunction

  function automatic void model_edge();
    ent_t e;
    bit ok;
    if (bus.flush) begin
      for (int i = 0; i < D; i++) pipe[i].v = 1'b0;
      ref_err = 1'b0;
    end else if (bus.stall) begin
      ref_err = 1'b0;
    end else begin
      ok  = int'(bus.sel) < NI;
      e.d = ok ? cand[bus.sel] : '0;
      e.v = bus.in_valid && ok;
      pipe.push_front(e);
      void'(pipe.pop_back());
      ref_err = bus.in_valid && !ok;
    end
  endfunction

  function automatic logic [D-1:0] ref_match(input logic [W-1:0] s);
    logic [D-1:0] m = '0;
    for (int i = 0; i < D; i++)
      m[i] = pipe[i].v && pipe[i].d == s && s != 0;
    return m;
  endfunction

  function automatic logic [D-1:0] ref_pri(input logic [D-1:0] m);
    for (int i = 0; i < D; i++)
      if (m[i]) return D'(1) << i;
    return '0;
  endfunction

  task automatic check_all(input string tag);
    logic [D-1:0] ma, mb;
    ma = ref_match(bus.src_a);
    mb = ref_match(bus.src_b);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("%s dest%0d", tag, i),
          32'(bus.stage_dest[i*W +: W]), 32'(pipe[i].d));
      chk($sformatf("%s vld%0d", tag, i),
          32'(bus.stage_valid[i]), 32'(pipe[i].v));
    end
    chk({tag, " out_dest"}, 32'(bus.out_dest), 32'(pipe[D-1].d));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(pipe[D-1].v));
    chk({tag, " a_match"}, 32'(bus.fwd_a_match), 32'(ma));
    chk({tag, " a_pri"}, 32'(bus.fwd_a_pri), 32'(ref_pri(ma)));
    chk({tag, " b_match"}, 32'(bus.fwd_b_match), 32'(mb));
    chk({tag, " b_pri"}, 32'(bus.fwd_b_pri), 32'(ref_pri(mb)));
    chk({tag, " sel_err"}, 32'(bus.sel_err), 32'(ref_err));
  endtask

  task automatic set_cands(input logic [W-1:0] c0, c1, c2);
    cand[0] = c0;
    cand[1] = c1;
    cand[2] = c2;
    bus.in_bus = {c2, c1, c0};
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [W-1:0] d, input string tag);
    set_cands(d, 5'd1, 5'd2);
    bus.sel = 2'd0;
    bus.in_valid = 1'b1;
    tick(tag);
  endtask

  initial begin
    bus.in_bus   = '0;
    bus.sel      = '0;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    model_clear();

    // reset state
    #12;
    chk("rst stage_valid", 32'(bus.stage_valid), 32'h0);
    chk("rst stage_dest", 32'(bus.stage_dest), 32'h0);
    chk("rst sel_err", 32'(bus.sel_err), 32'h0);
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;

    // select and latency
    set_cands(5'd8, 5'd17, 5'd31);
    bus.sel = 2'd1;
    bus.in_valid = 1'b1;
    tick("sel");
    chk("sel s0", 32'(bus.stage_dest[W-1:0]), 32'd17);
    chk("sel v0", 32'(bus.stage_valid[0]), 32'd1);
    bus.in_valid = 1'b0;
    tick("lat1");
    chk("lat1 out_valid", 32'(bus.out_valid), 32'd0);
    tick("lat2");
    chk("lat out_dest", 32'(bus.out_dest), 32'd17);
    chk("lat out_valid", 32'(bus.out_valid), 32'd1);

    // forwarding priority
    push(5'd9, "f0");
    push(5'd9, "f1");
    push(5'd12, "f2");
    bus.in_valid = 1'b0;
    bus.src_a = 5'd9;
    bus.src_b = 5'd12;
    #1;
    chk("fwd a_match", 32'(bus.fwd_a_match), 32'b110);
    chk("fwd a_pri", 32'(bus.fwd_a_pri), 32'b010);
    chk("fwd b_match", 32'(bus.fwd_b_match), 32'b001);
    chk("fwd b_pri", 32'(bus.fwd_b_pri), 32'b001);
    bus.src_b = 5'd9;
    #1;
    chk("fwd same", 32'(bus.fwd_b_match), 32'(bus.fwd_a_match));
    check_all("fwd");

    // stall then flush
    push(5'd7, "p7");
    push(5'd6, "p6");
    push(5'd5, "p5");
    bus.stall = 1'b1;
    bus.src_a = 5'd6;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall hold", 32'(bus.stage_dest), 32'({5'd7, 5'd6, 5'd5}));
    chk("stall vld", 32'(bus.stage_valid), 32'b111);
    bus.flush = 1'b1;
    tick("flush");
    chk("flush vld", 32'(bus.stage_valid), 32'h0);
    chk("flush ma", 32'(bus.fwd_a_match), 32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // out-of-range select
    bus.sel = 2'd3;
    bus.in_valid = 1'b1;
    tick("oor");
    chk("oor v0", 32'(bus.stage_valid[0]), 32'd0);
    chk("oor d0", 32'(bus.stage_dest[W-1:0]), 32'd0);
    chk("oor err", 32'(bus.sel_err), 32'd1);
    bus.in_valid = 1'b0;
    tick("oor2");
    chk("oor err off", 32'(bus.sel_err), 32'd0);

    // register-zero suppression
    bus.src_a = '0;
    push(5'd0, "z0");
    bus.in_valid = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      chk("zero ma", 32'(bus.fwd_a_match), 32'h0);
      tick("zero");
    end
    chk("zero out_valid", 32'(bus.out_valid), 32'd1);
    chk("zero out_dest", 32'(bus.out_dest), 32'd0);

    // asynchronous reset mid-stream
    push(5'd3, "r0");
    push(5'd4, "r1");
    push(5'd11, "r2");
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    chk("arst vld", 32'(bus.stage_valid), 32'h0);
    chk("arst dest", 32'(bus.stage_dest), 32'h0);
    check_all("arst");
    #2;
    rst = 1'b0;
    set_cands(5'd20, 5'd21, 5'd22);
    bus.sel = 2'd2;
    bus.in_valid = 1'b1;
    tick("post rst");
    chk("post rst d0", 32'(bus.stage_dest[W-1:0]), 32'd22);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      set_cands(W'($urandom), W'($urandom), W'($urandom));
      bus.sel      = SW'($urandom);
      bus.in_valid = 1'($urandom_range(0, 3) != 0);
      bus.stall    = 1'($urandom_range(0, 7) == 0);
      bus.flush    = 1'($urandom_range(0, 15) == 0);
      bus.src_a = ($urandom_range(0, 1) == 1)
                  ? pipe[$urandom_range(0, D-1)].d : W'($urandom);
      bus.src_b = ($urandom_range(0, 1) == 1)
                  ? pipe[$urandom_range(0, D-1)].d : W'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/dest_sel_pipe.md
Name: dest_sel_pipe

Overview:
- Parametrised successor to the 5-bit register-destination mux (rt/rd/$31 select), with a sequential pipeline added.
- Selects one of NUM_IN destination-register candidates and registers the result, with a valid bit, through a DEPTH-stage shift pipeline (EX/MEM/WB).
- Supports stall and flush.
- Compares each stage's destination against two decode-stage source registers to produce forwarding-hazard match vectors for the forwarding unit.

Parameters:
WIDTH, 5, bits per register address
NUM_IN, 4, number of candidate destination inputs (must be <= 2**SEL_W)
SEL_W, 2, select width
DEPTH, 3, pipeline stages carrying the destination (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_bus  input  NUM_IN*WIDTH  candidate destinations; candidate k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  candidate select
in_valid  input  1  instruction in issue slot writes a register
stall  input  1  hold all stages
flush  input  1  kill all in-flight entries
src_a  input  WIDTH  decode-stage source register A
src_b  input  WIDTH  decode-stage source register B
stage_dest  output  DEPTH*WIDTH  registered destination per stage; stage 0 at the LSBs
stage_valid  output  DEPTH  valid per stage
out_dest  output  WIDTH  equals stage DEPTH-1 destination (write-back)
out_valid  output  1  equals stage_valid[DEPTH-1]
fwd_a_match  output  DEPTH  raw per-stage match for src_a
fwd_a_pri  output  DEPTH  one-hot youngest match for src_a (lowest index wins); all zero if no match
fwd_b_match  output  DEPTH  raw per-stage match for src_b
fwd_b_pri  output  DEPTH  one-hot youngest match for src_b
sel_err  output  1  registered pulse: the previous accepted cycle had sel >= NUM_IN with in_valid=1

Behaviour:
- Reset, asynchronous on rst high: all stage_dest = 0, all stage_valid = 0, sel_err = 0. All match outputs are therefore 0.
- Combinational select:
  - mux_out = candidate[sel] when sel < NUM_IN.
  - Otherwise mux_out = 0 and the entry is marked invalid. This fixes the latch/undefined case of the old 3-way mux.
- Clock edge priority is flush > stall > advance:
  - flush = 1: all stage_valid <= 0; stage_dest contents are don't-care but are held. The in-slot entry is dropped even if stall = 1. sel_err <= 0.
  - stall = 1, no flush: every stage register holds; nothing is inserted. sel_err <= 0.
  - Advance: stage[i] <= stage[i-1] for i >= 1. stage[0].dest <= mux_out. stage[0].valid <= in_valid && (sel < NUM_IN). sel_err <= in_valid && (sel >= NUM_IN).
- Latency: an entry accepted at edge n appears at stage 0 after edge n and at out_dest/out_valid after edge n+DEPTH-1, assuming no stall.
- Match logic (combinational from registered state and live src inputs):
  - fwd_a_match[i] = stage_valid[i] && stage_dest[i] == src_a && src_a != 0. Register 0 never forwards.
  - fwd_b_match is the same with src_b.
  - fwd_x_pri isolates the lowest set bit of fwd_x_match.
  - src_a == src_b is legal; both vectors are then identical.
- Zero destination: a valid entry with dest 0 is carried through the pipeline but never matches.
- DEPTH = 1: out_dest equals stage 0; the pri vectors equal the match vectors.
- rst asserted mid-stream clears everything immediately, independent of clk. The first accept after deassertion behaves as a normal advance.

Test Plan:
- Reset and select: assert rst, check all outputs 0. Deassert rst. Load in_bus candidates {0:5'd8, 1:5'd17, 2:5'd31, 3:5'd4}, sel = 1, in_valid = 1, one cycle. Require stage0 = 17, valid = 1. Require out_dest = 17 and out_valid = 1 exactly 2 cycles later (DEPTH = 3).
- Forwarding priority: stream dest 9, then 9, then 12. Then set src_a = 9, src_b = 12. Require fwd_a_match = 3'b110, fwd_a_pri = 3'b010, fwd_b_match = fwd_b_pri = 3'b001.
- Stall/flush: with pipeline {5, 6, 7}, hold stall = 1 for 3 cycles; all stages must hold. Then pulse flush with stall = 1 and in_valid = 1; next cycle stage_valid = 0 and all match outputs are 0.
- Out-of-range select: NUM_IN = 3, sel = 2'b11, in_valid = 1. Require stage0 valid = 0, dest = 0, and sel_err = 1 for exactly one cycle. With sel = 3 and in_valid = 0, require sel_err = 0.
- Register-zero suppression: valid entry with dest 0 and src_a = 0. Require fwd_a_match = 0 while the entry traverses; require out_valid = 1 with out_dest = 0.
- Async reset mid-operation: assert rst between clock edges with a full valid pipeline. Outputs must clear before the next edge. After deassertion, a new entry accepts normally.
